// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch front end.
//
// Contents:
//   INSTR_W       - instruction width (always 32 bits)
//   PC_INC        - PC step between sequential instructions
//   fetch_entry_t - {pc, instr} prefetch entry at the default 32-bit PC width
//   cntWidth()    - width of a counter that must hold 0..depth inclusive
package fetch_pkg;

    localparam int INSTR_W    = 32;
    localparam int PC_INC     = 4;
    localparam int ENTRY_XLEN = 32;

    // A buffered fetch result at the default 32-bit PC width. The fetch unit
    // packs the same fields at its own XLEN; this type is the handy form for
    // code that works with 32-bit PCs.
    typedef struct packed {
        logic [ENTRY_XLEN-1:0] pc;
        logic [INSTR_W-1:0]    instr;
    } fetch_entry_t;

    // Counters that track occupancy need one extra bit so that a completely
    // full structure (count == depth) is representable.
    function automatic int cntWidth(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Bus bundles for the fetch unit.
//
// fetch_mem_if : instruction-memory request/response channel
//   req_valid/req_ready/req_addr   request handshake (fetch -> memory)
//   resp_valid/resp_data           in-order responses (memory -> fetch)
//   modport master = fetch side, modport slave = memory side
//
// fetch_dec_if : decode-facing channel
//   instr_valid/instr_ready/instr_data/instr_pc/instr_pc_plus4  buffer head
//   redirect_valid/redirect_target                             PC redirect
//   misaligned                                                 redirect alarm
//   modport master = fetch side, modport slave = decode side
interface fetch_mem_if import fetch_pkg::*; #(parameter int XLEN = 32);

    logic               req_valid;
    logic               req_ready;
    logic [XLEN-1:0]    req_addr;
    logic               resp_valid;
    logic [INSTR_W-1:0] resp_data;

    modport master (
        output req_valid, req_addr,
        input  req_ready, resp_valid, resp_data
    );

    modport slave (
        input  req_valid, req_addr,
        output req_ready, resp_valid, resp_data
    );

endinterface

interface fetch_dec_if import fetch_pkg::*; #(parameter int XLEN = 32);

    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instr_data;
    logic [XLEN-1:0]    instr_pc;
    logic [XLEN-1:0]    instr_pc_plus4;
    logic               redirect_valid;
    logic [XLEN-1:0]    redirect_target;
    logic               misaligned;

    modport master (
        output instr_valid, instr_data, instr_pc, instr_pc_plus4, misaligned,
        input  instr_ready, redirect_valid, redirect_target
    );

    modport slave (
        input  instr_valid, instr_data, instr_pc, instr_pc_plus4, misaligned,
        output instr_ready, redirect_valid, redirect_target
    );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO used as the fetch prefetch buffer.
//
// Ports:
//   clk, reset    clock and asynchronous active-high reset
//   push, wdata   write one entry (ignored when full)
//   pop           drop the head entry (ignored when empty)
//   flush         empty the FIFO; overrides push and pop in the same cycle
//   rdata         head entry, shown combinationally
//   count         number of valid entries (0..DEPTH)
//   full, empty   occupancy flags
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 4,
    localparam int CW    = cntWidth(DEPTH),
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] storage [DEPTH];
    logic [AW-1:0]    wrPtr;
    logic [AW-1:0]    rdPtr;
    logic             doPush;
    logic             doPop;

    // Occupancy flags and the guarded push/pop strobes. DEPTH is a power of
    // two, so the pointers wrap for free at their natural width.
    always_comb begin
        full   = (count == DEPTH_C);
        empty  = (count == '0);
        doPush = push && !full;
        doPop  = pop && !empty;
        rdata  = storage[rdPtr];
    end

    // Entry storage carries no reset: a slot is only ever read after it has
    // been written, because count gates the head.
    always_ff @(posedge clk) begin
        if (doPush && !flush) begin
            storage[wrPtr] <= wdata;
        end
    end

    // Pointers and count. A flush wins over everything else so that a head
    // pop in the same cycle is simply absorbed by the clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else if (flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + AW'(1);
            end
            if (doPop) begin
                rdPtr <= rdPtr + AW'(1);
            end
            count <= count + CW'(doPush) - CW'(doPop);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Decoupled instruction-fetch stage.
//
// Issues word-aligned fetch requests to a variable-latency memory, tracks how
// many are in flight, buffers responses together with their PC in a prefetch
// FIFO and presents the head to decode with a valid/ready handshake.
// Redirects flush the buffer and discard every response that was still in
// flight at the redirect edge.
//
// Ports:
//   clk, reset  clock and asynchronous active-high reset
//   mem         fetch_mem_if.master : request/response channel to memory
//   dec         fetch_dec_if.master : head of buffer, redirect, misaligned flag
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN            = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR    = '0,
    parameter int              FIFO_DEPTH      = 4,
    parameter int              MAX_OUTSTANDING = 2
) (
    input logic         clk,
    input logic         reset,
    fetch_mem_if.master mem,
    fetch_dec_if.master dec
);

    localparam int              CW        = cntWidth(FIFO_DEPTH);
    localparam int              EW        = XLEN + INSTR_W;
    localparam logic [CW-1:0]   MAX_OUT   = CW'(MAX_OUTSTANDING);
    localparam logic [CW:0]     DEPTH_LIM = (CW + 1)'(FIFO_DEPTH);
    localparam logic [XLEN-1:0] PC_STEP   = XLEN'(PC_INC);

    logic [XLEN-1:0] fetchPc;
    logic [XLEN-1:0] respPc;
    logic [XLEN-1:0] alignedTarget;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   outstandingNext;
    logic [CW-1:0]   dropCnt;
    logic [CW-1:0]   fifoCount;
    logic [CW:0]     creditSum;
    logic            reqFire;
    logic            respKeep;
    logic            popFire;
    logic            fifoFull;
    logic            fifoEmpty;
    logic            misalignedQ;
    logic [EW-1:0]   pushData;
    logic [EW-1:0]   headData;

    // Request credit: a request may only go out if both the in-flight limit
    // and a reserved FIFO slot are available. Reserving the slot at issue
    // time is what lets responses arrive without any back-pressure.
    always_comb begin
        creditSum     = {1'b0, outstanding} + {1'b0, fifoCount};
        reqFire       = mem.req_valid && mem.req_ready;
        outstandingNext = outstanding + CW'(reqFire) - CW'(mem.resp_valid);
        alignedTarget = {dec.redirect_target[XLEN-1:2], 2'b00};
        // A response is kept only if it belongs to the current PC stream:
        // no pending drops and no redirect landing on this very edge. The
        // full check never fires thanks to the credit rule.
        respKeep      = mem.resp_valid && (dropCnt == '0) && !dec.redirect_valid && !fifoFull;
        popFire       = dec.instr_valid && dec.instr_ready;
        pushData      = {respPc, mem.resp_data};
    end

    assign mem.req_valid      = !reset && (outstanding < MAX_OUT) && (creditSum < DEPTH_LIM);
    assign mem.req_addr       = fetchPc;
    assign dec.instr_valid    = !fifoEmpty;
    assign dec.instr_pc       = headData[EW-1:INSTR_W];
    assign dec.instr_data     = headData[INSTR_W-1:0];
    assign dec.instr_pc_plus4 = headData[EW-1:INSTR_W] + PC_STEP;
    assign dec.misaligned     = misalignedQ;

    // PC, credit and drop bookkeeping. On a redirect every request still in
    // flight after this edge (including one accepted right now) belongs to
    // the old stream, so that many future responses are marked for discard.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetchPc     <= RESET_VECTOR;
            respPc      <= RESET_VECTOR;
            outstanding <= '0;
            dropCnt     <= '0;
            misalignedQ <= 1'b0;
        end else begin
            outstanding <= outstandingNext;
            misalignedQ <= dec.redirect_valid && (dec.redirect_target[1:0] != 2'b00);
            if (dec.redirect_valid) begin
                fetchPc <= alignedTarget;
                respPc  <= alignedTarget;
                dropCnt <= outstandingNext;
            end else begin
                if (reqFire) begin
                    fetchPc <= fetchPc + PC_STEP;
                end
                if (respKeep) begin
                    respPc <= respPc + PC_STEP;
                end
                if (mem.resp_valid && (dropCnt != '0)) begin
                    dropCnt <= dropCnt - CW'(1);
                end
            end
        end
    end

    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (respKeep),
        .pop   (popFire),
        .flush (dec.redirect_valid),
        .wdata (pushData),
        .rdata (headData),
        .count (fifoCount),
        .full  (fifoFull),
        .empty (fifoEmpty)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit (XLEN=32, RESET_VECTOR=0x100, DEPTH=4,
// MAX_OUTSTANDING=2). A behavioural memory answers requests in order after a
// programmable latency; stimulus pushes the expected delivery stream into a
// scoreboard queue and a separate monitor compares every decode handshake.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam logic [31:0] RV = 32'h0000_0100;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    logic clk = 1'b0;
    logic reset = 1'b0;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int memLatency = 1;
    int firstValidCyc = -1;

    pend_t        pending[$];
    logic [31:0]  acceptLog[$];
    int           acceptCyc[$];
    fetch_entry_t expQ[$];
    fetch_entry_t monEntry;

    fetch_mem_if #(.XLEN(32)) memBus ();
    fetch_dec_if #(.XLEN(32)) decBus ();

    fetch_unit #(
        .XLEN            (32),
        .RESET_VECTOR    (RV),
        .FIFO_DEPTH      (4),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .mem   (memBus),
        .dec   (decBus)
    );

    // Free-running clock and cycle counter used to time memory responses.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] memData(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic logic [31:0] logAt(input int i);
        if (i < acceptLog.size()) return acceptLog[i];
        return 32'hDEAD_BEEF;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic pushExp(input logic [31:0] start, input int n);
        fetch_entry_t e;
        for (int i = 0; i < n; i++) begin
            e.pc    = start + 32'(4 * i);
            e.instr = memData(e.pc);
            expQ.push_back(e);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Memory model: responds in order, one per cycle, once the latency has
    // elapsed; forgets everything while reset is high.
    initial begin
        pend_t p;
        memBus.req_ready  = 1'b1;
        memBus.resp_valid = 1'b0;
        memBus.resp_data  = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                pending.delete();
                memBus.resp_valid = 1'b0;
            end else begin
                if (pending.size() > 0 && pending[0].due <= cyc) begin
                    p = pending.pop_front();
                    memBus.resp_valid = 1'b1;
                    memBus.resp_data  = memData(p.addr);
                end else begin
                    memBus.resp_valid = 1'b0;
                    memBus.resp_data  = '0;
                end
                if (memBus.req_valid && memBus.req_ready) begin
                    pending.push_back('{addr: memBus.req_addr, due: cyc + memLatency});
                    acceptLog.push_back(memBus.req_addr);
                    acceptCyc.push_back(cyc);
                end
            end
        end
    end

    // Scoreboard monitor: every head handshake must match the next expected entry.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!reset && decBus.instr_valid && decBus.instr_ready) begin
                if (expQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_instr: got pc %h, expected none", decBus.instr_pc);
                end else begin
                    monEntry = expQ.pop_front();
                    checkOutput("instr_pc", decBus.instr_pc, monEntry.pc);
                    checkOutput("instr_pc_plus4", decBus.instr_pc_plus4, monEntry.pc + 32'd4);
                    checkOutput("instr_data", decBus.instr_data, monEntry.instr);
                end
            end
        end
    end

    task automatic resetDut(input int nExp);
        reset = 1'b1;
        decBus.instr_ready    = 1'b0;
        decBus.redirect_valid = 1'b0;
        #1;
        checkOutput("rst_req_valid", 32'(memBus.req_valid), 32'd0);
        checkOutput("rst_instr_valid", 32'(decBus.instr_valid), 32'd0);
        checkOutput("rst_misaligned", 32'(decBus.misaligned), 32'd0);
        checkOutput("rst_req_addr", memBus.req_addr, RV);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        acceptLog.delete();
        acceptCyc.delete();
        expQ.delete();
        pushExp(RV, nExp);
    endtask

    // Redirect during the current cycle; the expected stream restarts at the
    // aligned target once the redirect edge has passed.
    task automatic applyStimulus(input logic [31:0] target, input int nExp);
        decBus.redirect_valid  = 1'b1;
        decBus.redirect_target = target;
        @(posedge clk);
        #1;
        decBus.redirect_valid = 1'b0;
        expQ.delete();
        acceptLog.delete();
        acceptCyc.delete();
        pushExp({target[31:2], 2'b00}, nExp);
    endtask

    task automatic deliver(input int k, input string tag);
        int got = 0;
        int budget = 0;
        while (got < k && budget < 60) begin
            step();
            decBus.instr_ready = 1'b1;
            if (decBus.instr_valid) begin
                got++;
                if (firstValidCyc < 0) firstValidCyc = cyc;
            end
            budget++;
        end
        @(posedge clk);
        #1;
        decBus.instr_ready = 1'b0;
        checkOutput({tag, "_delivered"}, 32'(got), 32'(k));
    endtask

    task automatic waitAccepts(input int n);
        int w = 0;
        while (acceptLog.size() < n && w < 20) begin
            step();
            w++;
        end
        checkOutput("t3_two_in_flight", 32'(acceptLog.size()), 32'(n));
    endtask

    task automatic waitReqAndResp();
        int w = 0;
        logic found = 1'b0;
        while (!found && w < 20) begin
            step();
            found = memBus.req_valid && memBus.req_ready && memBus.resp_valid;
            w++;
        end
        checkOutput("t4_req_resp_same_cycle", 32'(found), 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        decBus.instr_ready     = 1'b0;
        decBus.redirect_valid  = 1'b0;
        decBus.redirect_target = '0;
        #2;

        // Sequential fetch from the reset vector, latency 1.
        memLatency    = 1;
        firstValidCyc = -1;
        resetDut(3);
        deliver(3, "t1");
        checkOutput("t1_addr0", logAt(0), 32'h100);
        checkOutput("t1_addr1", logAt(1), 32'h104);
        checkOutput("t1_addr2", logAt(2), 32'h108);
        checkOutput("t1_latency", 32'(firstValidCyc - acceptCyc[0]), 32'd2);

        // Decode stalled: exactly DEPTH entries buffered, then drained in order.
        resetDut(6);
        repeat (20) step();
        checkOutput("t2_accepted", 32'(acceptLog.size()), 32'd4);
        checkOutput("t2_req_stalled", 32'(memBus.req_valid), 32'd0);
        checkOutput("t2_head_valid", 32'(decBus.instr_valid), 32'd1);
        deliver(6, "t2");
        checkOutput("t2_resume_addr", logAt(4), 32'h110);

        // Redirect with two stale requests in flight, latency 3.
        memLatency = 3;
        resetDut(0);
        waitAccepts(2);
        step();
        checkOutput("t3_req_blocked", 32'(memBus.req_valid), 32'd0);
        applyStimulus(32'h200, 3);
        checkOutput("t3_misaligned_low", 32'(decBus.misaligned), 32'd0);
        deliver(3, "t3");

        // Redirect coinciding with a request acceptance and a response arrival.
        memLatency = 1;
        resetDut(0);
        waitReqAndResp();
        applyStimulus(32'h300, 3);
        deliver(3, "t4");

        // Misaligned target: one-cycle pulse, fetch resumes at aligned PC.
        step();
        applyStimulus(32'h203, 2);
        checkOutput("t5_misaligned_pulse", 32'(decBus.misaligned), 32'd1);
        @(posedge clk);
        #1;
        checkOutput("t5_misaligned_clear", 32'(decBus.misaligned), 32'd0);
        deliver(2, "t5");
        checkOutput("t5_resume_addr", logAt(0), 32'h200);

        // PC wrap at the top of the address space.
        step();
        applyStimulus(32'hFFFF_FFFC, 3);
        deliver(3, "t6");
        checkOutput("t6_addr0", logAt(0), 32'hFFFF_FFFC);
        checkOutput("t6_wrap_addr", logAt(1), 32'h0000_0000);

        // Reset in the middle of activity, then restart from the reset vector.
        memLatency = 3;
        repeat (3) step();
        checkOutput("t7_busy_before_reset", 32'(decBus.instr_valid), 32'd1);
        resetDut(2);
        deliver(2, "t7");
        checkOutput("t7_restart_addr", logAt(0), RV);

        checkOutput("leftover_expected", 32'(expQ.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
